// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-programmable 1..MAX_LEN bit pattern.
// Supports overlapping/non-overlapping detection, a Mealy strobe, a registered strobe and a saturating count.
module seq_detect_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 'b101,
  parameter int                 RST_LEN     = 3,
  parameter bit                 RST_OVERLAP = 1'b0,
  localparam int                LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [MAX_LEN-1:0] r_pat;
  logic [LW-1:0]      r_len;
  logic               r_ovl;
  logic [MAX_LEN-2:0] r_hist;
  logic [LW-1:0]      r_fill;
  logic               r_match_q;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_fill_ok;
  logic               w_match;
  logic [LW-1:0]      w_len_clamped;

  assign w_accept  = din_valid & ~cfg_load;
  assign w_window  = {r_hist, din};
  // Shifting by len == MAX_LEN empties the vector, giving an all-ones mask.
  assign w_mask    = ~({MAX_LEN{1'b1}} << r_len);
  assign w_fill_ok = ({1'b0, r_fill} + (LW + 1)'(1)) >= {1'b0, r_len};
  assign w_match   = rst_n & w_accept & w_fill_ok & (((w_window ^ r_pat) & w_mask) == '0);

  always_comb begin
    w_len_clamped = cfg_len;
    if (cfg_len == '0) begin
      w_len_clamped = LW'(1);
    end else if (cfg_len > LW'(MAX_LEN)) begin
      w_len_clamped = LW'(MAX_LEN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat <= RST_PATTERN;
      r_len <= LW'(RST_LEN);
      r_ovl <= RST_OVERLAP;
    end else if (cfg_load) begin
      r_pat <= cfg_pattern;
      r_len <= w_len_clamped;
      r_ovl <= cfg_overlap;
    end
  end

  // In non-overlap mode the matched bits are consumed by restarting the fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (cfg_load) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_accept) begin
      r_hist <= w_window[MAX_LEN-2:0];
      if (w_match && !r_ovl) begin
        r_fill <= '0;
      end else if (r_fill != LW'(MAX_LEN - 1)) begin
        r_fill <= r_fill + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_match_q <= w_match;
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_match && !(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign match     = w_match;
  assign match_q   = r_match_q;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: vector table plus hand-written reset and counter sequences.
// A second instance with a 2-bit counter shares the stimulus for the saturation checks.
module tb_seq_detect_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic        din_valid;
  logic        cfg_load;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic        cnt_clr;
  logic        match, match_q;
  logic [15:0] match_cnt;
  logic        match_b, match_q_b;
  logic [1:0]  match_cnt_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match), .match_q(match_q), .match_cnt(match_cnt)
  );

  seq_detect_param #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .match(match_b), .match_q(match_q_b), .match_cnt(match_cnt_b)
  );

  typedef struct {
    logic       d, v, ld, clr;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       em;
    int         ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic add(input logic d, v, ld, clr, input logic [7:0] pat, input logic [3:0] len,
                     input logic ovl, em, input int ecnt);
    vec_t t;
    t.d = d; t.v = v; t.ld = ld; t.clr = clr; t.pat = pat; t.len = len;
    t.ovl = ovl; t.em = em; t.ecnt = ecnt;
    tbl.push_back(t);
  endtask

  // Bit with no configuration change.
  task automatic addb(input logic d, v, em, input int ecnt);
    add(d, v, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, em, ecnt);
  endtask

  // One clock: drive at negedge, check Mealy strobe, then registered outputs after posedge.
  task automatic cyc(input logic d, v, ld, clr, input logic [7:0] pat, input logic [3:0] len,
                     input logic ovl, em, input int ecnt, input string nm);
    @(negedge clk);
    din = d; din_valid = v; cfg_load = ld; cnt_clr = clr;
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    #1 chk({nm, " match"}, int'(match), int'(em));
    @(posedge clk);
    #1;
    chk({nm, " match_q"}, int'(match_q), int'(em));
    chk({nm, " match_cnt"}, int'(match_cnt), ecnt);
  endtask

  task automatic bit1(input logic d, em, input int ecnt, input string nm);
    cyc(d, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, em, ecnt, nm);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b1; din_valid = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;

    // Reset defaults: 101, non-overlap
    addb(1, 1, 0, 0); addb(0, 1, 0, 0); addb(1, 1, 1, 1); addb(0, 1, 0, 1); addb(1, 1, 0, 1);
    // Overlap 101
    add(0, 1, 1, 1, 8'h05, 4'd3, 1, 0, 0);
    addb(1, 1, 0, 0); addb(0, 1, 0, 0); addb(1, 1, 1, 1); addb(0, 1, 0, 1); addb(1, 1, 1, 2);
    // Gaps (idle cycles carry din=1 which would complete 101 if not gated)
    add(0, 1, 1, 1, 8'h05, 4'd3, 0, 0, 0);
    addb(1, 1, 0, 0); addb(1, 0, 0, 0); addb(0, 1, 0, 0); addb(1, 0, 0, 0); addb(1, 0, 0, 0);
    addb(1, 1, 1, 1);
    // 0x5A len 8, reloaded mid-pattern so stale history would complete the pattern
    add(0, 1, 1, 1, 8'h5A, 4'd8, 0, 0, 0);
    addb(0, 1, 0, 0); addb(1, 1, 0, 0); addb(0, 1, 0, 0); addb(1, 1, 0, 0);
    addb(1, 1, 0, 0); addb(0, 1, 0, 0); addb(1, 1, 0, 0);
    add(0, 1, 1, 0, 8'h5A, 4'd8, 0, 0, 0);
    addb(0, 1, 0, 0);
    addb(0, 1, 0, 0); addb(1, 1, 0, 0); addb(0, 1, 0, 0); addb(1, 1, 0, 0);
    addb(1, 1, 0, 0); addb(0, 1, 0, 0); addb(1, 1, 0, 0); addb(0, 1, 1, 1);
    // cfg_len = 0 clamps to 1
    add(0, 1, 1, 1, 8'h01, 4'd0, 0, 0, 0);
    addb(1, 1, 1, 1); addb(0, 1, 0, 1); addb(1, 1, 1, 2);
    // cfg_len = 12 clamps to 8; A5 overlaps itself by 3 bits
    add(0, 1, 1, 1, 8'hA5, 4'd12, 1, 0, 0);
    addb(1, 1, 0, 0); addb(0, 1, 0, 0); addb(1, 1, 0, 0); addb(0, 1, 0, 0);
    addb(0, 1, 0, 0); addb(1, 1, 0, 0); addb(0, 1, 0, 0); addb(1, 1, 1, 1);
    addb(0, 1, 0, 1); addb(0, 1, 0, 1); addb(1, 1, 0, 1); addb(0, 1, 0, 1); addb(1, 1, 1, 2);

    repeat (2) @(posedge clk);
    #1;
    chk("reset match", int'(match), 0);
    chk("reset match_q", int'(match_q), 0);
    chk("reset match_cnt", int'(match_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].d, tbl[i].v, tbl[i].ld, tbl[i].clr, tbl[i].pat, tbl[i].len, tbl[i].ovl,
          tbl[i].em, tbl[i].ecnt, $sformatf("vec%0d", i));
    end

    // Saturating 2-bit counter, len 1 pattern 1
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 1'b0, 1'b0, 0, "cntload");
    chk("cntload cnt_b", int'(match_cnt_b), 0);
    for (int i = 0; i < 5; i++) begin
      bit1(1'b1, 1'b1, i + 1, $sformatf("cnt%0d", i));
      chk($sformatf("cnt%0d cnt_b", i), int'(match_cnt_b), (i < 3) ? i + 1 : 3);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 0, "clrwin");
    chk("clrwin cnt_b", int'(match_cnt_b), 0);
    bit1(1'b1, 1'b1, 1, "aftclr");
    chk("aftclr cnt_b", int'(match_cnt_b), 1);

    // Reset returns configuration to 101 and clears the count
    @(negedge clk);
    rst_n = 1'b0; din = 1'b1; din_valid = 1'b1; cnt_clr = 1'b0;
    #1;
    chk("rst2 match", int'(match), 0);
    chk("rst2 match_cnt", int'(match_cnt), 0);
    chk("rst2 cnt_b", int'(match_cnt_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bit1(1'b1, 1'b0, 0, "cfgrst1");
    bit1(1'b0, 1'b0, 0, "cfgrst0");
    // Mid-cycle async reset after 1,0: partial match must not survive
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("midrst match_q", int'(match_q), 0);
    #1 rst_n = 1'b1;
    bit1(1'b1, 1'b0, 0, "post1");
    bit1(1'b1, 1'b0, 0, "post2");
    bit1(1'b0, 1'b0, 0, "post3");
    bit1(1'b1, 1'b1, 1, "post4");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
